// File: rtl/acc_unit_if.sv
// -----------------------------------------------------------------------------
// acc_unit_if
// Bundles the command handshake and the data-memory handshake of acc_unit.
//
// Signals (named as on the original flat port list):
//   Command:  in_valid, in_ready, acc_ctrl[2:0], fn[2:0], operand[7:0],
//             mem_ld, mem_st
//   Memory:   mem_req, mem_we, mem_addr[7:0], mem_wdata[7:0],
//             mem_rdata[7:0], mem_ack
//
// Modports:
//   slave  - the accumulator unit (consumes commands, drives memory requests)
//   master - the environment (issues commands, answers memory requests)
// -----------------------------------------------------------------------------
interface acc_unit_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] acc_ctrl;
    logic [2:0] fn;
    logic [7:0] operand;
    logic       mem_ld;
    logic       mem_st;

    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    modport slave (
        input  in_valid, acc_ctrl, fn, operand, mem_ld, mem_st,
        input  mem_rdata, mem_ack,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, acc_ctrl, fn, operand, mem_ld, mem_st,
        output mem_rdata, mem_ack,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/acc_unit.sv
// -----------------------------------------------------------------------------
// acc_unit
// 8-bit accumulator execution unit with a single-port data-memory handshake.
// One command is accepted in IDLE; register/immediate operations finish in
// EXEC one edge later, memory load/store waits in MEM for mem_ack.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   bus       if   acc_unit_if.slave: command + memory handshake
//   rf_we     out  one-cycle register-file write strobe (MOVE)
//   rf_wdata  out  register-file write data (acc at MOVE time)
//   acc       out  accumulator
//   zero      out  registered (acc == 0)
//   done      out  one-cycle completion pulse
//
// Build option:
//   ACC_SAT_EN  when defined, add saturates at 255 and sub at 0;
//               otherwise both wrap modulo 256.
// -----------------------------------------------------------------------------
module acc_unit (
    input  logic        clk,
    input  logic        rst_n,
    acc_unit_if.slave   bus,
    output logic        rf_we,
    output logic [7:0]  rf_wdata,
    output logic [7:0]  acc,
    output logic        zero,
    output logic        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MEM  = 2'd2;

    localparam logic [2:0] CTRL_UNARY  = 3'b001;
    localparam logic [2:0] CTRL_BINARY = 3'b010;
    localparam logic [2:0] CTRL_MOVE   = 3'b101;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       in_ready_q;

    // Latched command fields
    logic [2:0] ctrl_q;
    logic [2:0] fn_q;
    logic [7:0] operand_q;
    logic       ld_q;
    logic       st_q;

    logic       accept;
    logic       mem_cmd;
    logic [7:0] add_res;
    logic [7:0] sub_res;
    logic [7:0] exec_acc;
    logic       exec_move;
    logic [7:0] acc_next;
    logic       done_next;
    logic       rf_we_next;

    assign accept  = bus.in_valid && in_ready_q;
    // Exactly one flag selects a memory access; both set degrades to HOLD in EXEC.
    assign mem_cmd = bus.mem_ld ^ bus.mem_st;

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------
`ifdef ACC_SAT_EN
    logic [8:0] sum_full;
    always_comb begin
        sum_full = {1'b0, acc} + {1'b0, operand_q};
        add_res  = sum_full[8] ? 8'hFF : sum_full[7:0];
        sub_res  = (operand_q > acc) ? 8'h00 : (acc - operand_q);
    end
`else
    always_comb begin
        add_res = acc + operand_q;
        sub_res = acc - operand_q;
    end
`endif

    // ------------------------------------------------------------------
    // EXEC result: HOLD and unknown codes fall through as acc unchanged
    // ------------------------------------------------------------------
    always_comb begin
        exec_acc  = acc;
        exec_move = 1'b0;
        if (!(ld_q && st_q)) begin
            case (ctrl_q)
                CTRL_BINARY: begin
                    case (fn_q)
                        3'b000:  exec_acc = add_res;
                        3'b001:  exec_acc = sub_res;
                        3'b010:  exec_acc = acc & operand_q;
                        3'b011:  exec_acc = acc | operand_q;
                        default: exec_acc = acc;
                    endcase
                end
                CTRL_UNARY: begin
                    case (fn_q)
                        3'b101:  exec_acc = {acc[6:0], 1'b0};
                        3'b110:  exec_acc = {1'b0, acc[7:1]};
                        3'b111:  exec_acc = ~acc;
                        default: exec_acc = acc;
                    endcase
                end
                CTRL_MOVE: exec_move = 1'b1;
                default:   exec_acc  = acc;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        acc_next   = acc;
        done_next  = 1'b0;
        rf_we_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = mem_cmd ? ST_MEM : ST_EXEC;
                end
            end
            ST_EXEC: begin
                acc_next   = exec_acc;
                rf_we_next = exec_move;
                done_next  = 1'b1;
                next_state = ST_IDLE;
            end
            ST_MEM: begin
                if (bus.mem_ack) begin
                    if (ld_q) begin
                        acc_next = bus.mem_rdata;
                    end
                    done_next  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_ready_q <= 1'b0;
            acc        <= '0;
            zero       <= 1'b1;
            done       <= 1'b0;
            rf_we      <= 1'b0;
            rf_wdata   <= '0;
            ctrl_q     <= '0;
            fn_q       <= '0;
            operand_q  <= '0;
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
        end else begin
            state      <= next_state;
            // Registered so in_ready stays low throughout reset and rises
            // at the first edge after release.
            in_ready_q <= (next_state == ST_IDLE);
            acc        <= acc_next;
            zero       <= (acc_next == 8'h00);
            done       <= done_next;
            rf_we      <= rf_we_next;
            if (rf_we_next) begin
                rf_wdata <= acc;
            end
            if (accept) begin
                ctrl_q    <= bus.acc_ctrl;
                fn_q      <= bus.fn;
                operand_q <= bus.operand;
                ld_q      <= bus.mem_ld;
                st_q      <= bus.mem_st;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from registers only
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_ready_q;
    assign bus.mem_req   = (state == ST_MEM);
    assign bus.mem_we    = (state == ST_MEM) && st_q;
    assign bus.mem_addr  = operand_q;
    assign bus.mem_wdata = acc;

endmodule

// File: tb/tb_acc_unit.sv
// -----------------------------------------------------------------------------
// tb_acc_unit
// Directed, table-driven bench for acc_unit plus hand-written sequences for
// memory load/store, MOVE and reset during a memory wait.
// Build option ACC_SAT_EN selects saturating expectations.
// -----------------------------------------------------------------------------
module tb_acc_unit;

    logic       clk;
    logic       rst_n;
    logic       rf_we;
    logic [7:0] rf_wdata;
    logic [7:0] acc;
    logic       zero;
    logic       done;

    int unsigned n_tests;
    int unsigned n_fail;

    acc_unit_if bus ();

    acc_unit u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rf_we    (rf_we),
        .rf_wdata (rf_wdata),
        .acc      (acc),
        .zero     (zero),
        .done     (done)
    );

`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [2:0] ctrl;
        logic [2:0] fn;
        logic [7:0] opnd;
        logic       ld;
        logic       st;
        logic [7:0] exp_acc;
    } vec_t;

    vec_t tbl [18];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one non-memory command and check the EXEC outcome.
    task automatic run_exec(input string tag, input logic [2:0] c, input logic [2:0] f,
                            input logic [7:0] op, input logic ld, input logic st,
                            input logic [7:0] exp);
        logic exp_move;
        exp_move = (c == 3'b101) && !(ld && st);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.acc_ctrl = c;
        bus.fn       = f;
        bus.operand  = op;
        bus.mem_ld   = ld;
        bus.mem_st   = st;
        chk($sformatf("%s/in_ready_idle", tag), 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        chk($sformatf("%s/in_ready_exec", tag), 32'(bus.in_ready), 32'd0);
        chk($sformatf("%s/done_early", tag), 32'(done), 32'd0);
        chk($sformatf("%s/mem_req", tag), 32'(bus.mem_req), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mem_ld   = 1'b0;
        bus.mem_st   = 1'b0;
        chk($sformatf("%s/acc", tag), 32'(acc), 32'(exp));
        chk($sformatf("%s/zero", tag), 32'(zero), 32'(exp == 8'h00));
        chk($sformatf("%s/done", tag), 32'(done), 32'd1);
        chk($sformatf("%s/rf_we", tag), 32'(rf_we), 32'(exp_move));
        if (exp_move) begin
            chk($sformatf("%s/rf_wdata", tag), 32'(rf_wdata), 32'(exp));
        end
    endtask

    initial begin
        int unsigned req_cycles;
        n_tests = 0;
        n_fail  = 0;

        // acc starts at 0 after reset; each row builds on the previous acc.
        tbl[0]  = '{3'b010, 3'b000, 8'h05, 1'b0, 1'b0, 8'h05};           // add 5
        tbl[1]  = '{3'b010, 3'b001, 8'h05, 1'b0, 1'b0, 8'h00};           // sub 5 -> 0
        tbl[2]  = '{3'b010, 3'b011, 8'hFA, 1'b0, 1'b0, 8'hFA};           // or -> 250
        tbl[3]  = '{3'b010, 3'b000, 8'h0A, 1'b0, 1'b0, SAT ? 8'hFF : 8'h04};
        tbl[4]  = '{3'b010, 3'b010, 8'h00, 1'b0, 1'b0, 8'h00};           // and 0
        tbl[5]  = '{3'b010, 3'b011, 8'h03, 1'b0, 1'b0, 8'h03};           // acc = 3
        tbl[6]  = '{3'b010, 3'b001, 8'h05, 1'b0, 1'b0, SAT ? 8'h00 : 8'hFE};
        tbl[7]  = '{3'b010, 3'b100, 8'h55, 1'b0, 1'b0, SAT ? 8'h00 : 8'hFE}; // fn 1xx
        tbl[8]  = '{3'b010, 3'b010, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{3'b010, 3'b011, 8'h81, 1'b0, 1'b0, 8'h81};
        tbl[10] = '{3'b001, 3'b101, 8'h00, 1'b0, 1'b0, 8'h02};           // shl
        tbl[11] = '{3'b001, 3'b110, 8'h00, 1'b0, 1'b0, 8'h01};           // shr
        tbl[12] = '{3'b001, 3'b111, 8'h00, 1'b0, 1'b0, 8'hFE};           // not
        tbl[13] = '{3'b001, 3'b000, 8'h00, 1'b0, 1'b0, 8'hFE};           // unary nop
        tbl[14] = '{3'b000, 3'b000, 8'h11, 1'b0, 1'b0, 8'hFE};           // HOLD
        tbl[15] = '{3'b011, 3'b000, 8'h33, 1'b0, 1'b0, 8'hFE};           // unknown code
        tbl[16] = '{3'b101, 3'b000, 8'h00, 1'b0, 1'b0, 8'hFE};           // MOVE
        tbl[17] = '{3'b010, 3'b000, 8'h01, 1'b1, 1'b1, 8'hFE};           // ld+st -> HOLD

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.acc_ctrl  = '0;
        bus.fn        = '0;
        bus.operand   = '0;
        bus.mem_ld    = 1'b0;
        bus.mem_st    = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst/acc", 32'(acc), 32'h00);
        chk("rst/zero", 32'(zero), 32'd1);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/rf_we", 32'(rf_we), 32'd0);
        chk("rst/rf_wdata", 32'(rf_wdata), 32'h00);
        chk("rst/mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst/mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst/mem_addr", 32'(bus.mem_addr), 32'h00);
        chk("rst/mem_wdata", 32'(bus.mem_wdata), 32'h00);
        chk("rst/in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst/in_ready_after", 32'(bus.in_ready), 32'd1);

        // Table-driven EXEC vectors
        for (int i = 0; i < 18; i++) begin
            run_exec($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].fn, tbl[i].opnd,
                     tbl[i].ld, tbl[i].st, tbl[i].exp_acc);
        end
        @(posedge clk); #1;
        chk("vec/done_one_cycle", 32'(done), 32'd0);

        // MOVE with 0x7E, then NOT
        run_exec("mv/clr", 3'b010, 3'b010, 8'h00, 1'b0, 1'b0, 8'h00);
        run_exec("mv/set", 3'b010, 3'b011, 8'h7E, 1'b0, 1'b0, 8'h7E);
        run_exec("mv/move", 3'b101, 3'b000, 8'h00, 1'b0, 1'b0, 8'h7E);
        @(posedge clk); #1;
        chk("mv/rf_we_one_cycle", 32'(rf_we), 32'd0);
        run_exec("mv/not", 3'b001, 3'b111, 8'h00, 1'b0, 1'b0, 8'h81);

        // mem_ack outside MEM is ignored
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h99;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ack/acc", 32'(acc), 32'h81);
        chk("idle_ack/done", 32'(done), 32'd0);
        chk("idle_ack/mem_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        bus.mem_ack = 1'b0;

        // Memory load, ack in the third MEM cycle
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.acc_ctrl  = 3'b001;
        bus.fn        = 3'b000;
        bus.operand   = 8'h20;
        bus.mem_ld    = 1'b1;
        bus.mem_st    = 1'b0;
        bus.mem_rdata = 8'hA5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mem_ld   = 1'b0;
        chk("ld/mem_addr", 32'(bus.mem_addr), 32'h20);
        req_cycles = 0;
        for (int c = 1; c <= 3; c++) begin
            if (bus.mem_req) req_cycles++;
            chk($sformatf("ld/mem_we_c%0d", c), 32'(bus.mem_we), 32'd0);
            chk($sformatf("ld/done_c%0d", c), 32'(done), 32'd0);
            if (c == 3) begin
                @(negedge clk);
                bus.mem_ack = 1'b1;
            end
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
        end
        chk("ld/req_cycles", 32'(req_cycles), 32'd3);
        chk("ld/mem_req_drop", 32'(bus.mem_req), 32'd0);
        chk("ld/acc", 32'(acc), 32'hA5);
        chk("ld/done", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("ld/done_one_cycle", 32'(done), 32'd0);

        // Memory store, same-cycle ack
        run_exec("st/clr", 3'b010, 3'b010, 8'h00, 1'b0, 1'b0, 8'h00);
        run_exec("st/set", 3'b010, 3'b011, 8'h3C, 1'b0, 1'b0, 8'h3C);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.acc_ctrl  = 3'b001;
        bus.fn        = 3'b000;
        bus.operand   = 8'h10;
        bus.mem_ld    = 1'b0;
        bus.mem_st    = 1'b1;
        bus.mem_rdata = 8'h55;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mem_st   = 1'b0;
        chk("st/mem_req", 32'(bus.mem_req), 32'd1);
        chk("st/mem_we", 32'(bus.mem_we), 32'd1);
        chk("st/mem_addr", 32'(bus.mem_addr), 32'h10);
        chk("st/mem_wdata", 32'(bus.mem_wdata), 32'h3C);
        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("st/mem_req_drop", 32'(bus.mem_req), 32'd0);
        chk("st/done", 32'(done), 32'd1);
        chk("st/acc", 32'(acc), 32'h3C);

        // Reset during a MEM wait
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.acc_ctrl = 3'b001;
        bus.operand  = 8'h40;
        bus.mem_ld   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mem_ld   = 1'b0;
        chk("rmem/mem_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmem/mem_req_low", 32'(bus.mem_req), 32'd0);
        chk("rmem/acc", 32'(acc), 32'h00);
        chk("rmem/zero", 32'(zero), 32'd1);
        chk("rmem/in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rmem/done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rmem/in_ready_after", 32'(bus.in_ready), 32'd1);
        chk("rmem/done_after", 32'(done), 32'd0);
        chk("rmem/acc_after", 32'(acc), 32'h00);
        run_exec("rmem/post", 3'b010, 3'b000, 8'h01, 1'b0, 1'b0, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
